// File: rtl/store_pkg.sv
// Shared encodings and lane-mask helper for the store read-modify-write unit.
// STORE_MISALIGN_TRAP_EN adds the TRAP state encoding.
package store_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    // Widest supported word is 256 bits; callers slice the low LANES bits.
    localparam int MAX_LANES = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3
`ifdef STORE_MISALIGN_TRAP_EN
        , ST_TRAP = 3'd4
`endif
    } state_e;

    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                       input logic [4:0] ofs);
        logic [MAX_LANES-1:0] m;
        case (size)
            SZ_HALF: m = MAX_LANES'(2'b11) << {ofs[4:1], 1'b0};
            SZ_BYTE: m = MAX_LANES'(1) << ofs;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: places the store payload into its lanes
// (little-endian) and keeps memory data in all other lanes.
module store_lane_merge
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int OFS_W = $clog2(LANES)
) (
    input  logic [1:0]        size_i,
    input  logic [OFS_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] merged_o
);

    logic [MAX_LANES-1:0] mask_full;
    logic [DATA_W-1:0]    placed;

    always_comb begin
        mask_full = lane_mask(size_i, 5'(offset_i));
        // Replicating the payload puts the right bytes in every candidate lane.
        case (size_i)
            SZ_BYTE: placed = {LANES{reg_data_i[7:0]}};
            SZ_HALF: placed = {(LANES / 2){reg_data_i[15:0]}};
            default: placed = reg_data_i;
        endcase
        merged_o = mem_data_i;
        for (int i = 0; i < LANES; i++) begin
            if (mask_full[i]) merged_o[i*8 +: 8] = placed[i*8 +: 8];
        end
    end

    if (LANES < MAX_LANES) begin : g_unused
        logic unused_mask_hi;
        assign unused_mask_hi = ^mask_full[MAX_LANES-1:LANES];
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: direct write for sw, read-modify-write for sh/sb on a data-memory port.
// Optional STORE_MISALIGN_TRAP_EN traps misaligned sh/sw instead of silently aligning.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1,
    localparam int LANES  = DATA_W / 8,
    localparam int OFS_W  = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
`ifdef STORE_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] merged;
    logic [1:0]        req_sz_n;
    logic [ADDR_W-1:0] addr_aligned;

    assign req_sz_n     = (req_size == SZ_HALF || req_size == SZ_BYTE) ? req_size : SZ_WORD;
    assign addr_aligned = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    store_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .size_i     (size_q),
        .offset_i   (addr_q[OFS_W-1:0]),
        .reg_data_i (data_q),
        .mem_data_i (mem_rdata),
        .merged_o   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                size_d  = req_sz_n;
                addr_d  = req_addr;
                data_d  = req_data;
                wdata_d = req_data;
                state_d = (req_sz_n == SZ_WORD) ? ST_WRITE : ST_READ;
`ifdef STORE_MISALIGN_TRAP_EN
                if ((req_sz_n == SZ_HALF && req_addr[0]) ||
                    (req_sz_n == SZ_WORD && req_addr[OFS_W-1:0] != '0))
                    state_d = ST_TRAP;
`endif
            end
            ST_READ: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Terminal count marks the cycle mem_rdata is valid.
                if (cnt_q == '0) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef STORE_MISALIGN_TRAP_EN
        misalign  = 1'b0;
`endif
        if (!reset) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE:  req_ready = 1'b1;
                ST_READ: begin
                    mem_rd   = 1'b1;
                    mem_addr = addr_aligned;
                end
                ST_WAIT:  mem_addr = addr_aligned;
                ST_WRITE: begin
                    mem_wr    = 1'b1;
                    done      = 1'b1;
                    mem_addr  = addr_aligned;
                    mem_wdata = wdata_q;
                end
`ifdef STORE_MISALIGN_TRAP_EN
                ST_TRAP: begin
                    done     = 1'b1;
                    misalign = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit, run on two instances (MEM_LAT 1 and 3).
module tb_store_rmw_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          trap;
    } wr_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } rd_exp_t;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        reset;
        logic        req_valid, req_ready;
        logic [1:0]  req_size;
        logic [31:0] req_addr, req_data;
        logic [31:0] mem_addr, mem_rdata, mem_wdata;
        logic        mem_rd, mem_wr, done, busy;
`ifdef STORE_MISALIGN_TRAP_EN
        logic        misalign;
`endif
        bit          fin = 1'b0;

        logic [31:0] mem_arr [256] = '{default: 32'h1122_3344};
        logic [31:0] ref_arr [256] = '{default: 32'h1122_3344};
        wr_exp_t     wq[$];
        rd_exp_t     rq[$];
        wr_exp_t     we;
        rd_exp_t     re;
        logic        mis_l;
        int          rd_due = -1;
        logic [31:0] rd_word;

        store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_size  (req_size),
            .req_addr  (req_addr),
            .req_data  (req_data),
            .mem_addr  (mem_addr),
            .mem_rd    (mem_rd),
            .mem_rdata (mem_rdata),
            .mem_wr    (mem_wr),
            .mem_wdata (mem_wdata),
            .done      (done),
`ifdef STORE_MISALIGN_TRAP_EN
            .misalign  (misalign),
`endif
            .busy      (busy)
        );

        // Memory: read data is valid only in the cycle exactly LAT after mem_rd.
        always @(negedge clk) begin
            if (mem_wr) mem_arr[mem_addr[9:2]] = mem_wdata;
            if (cyc == rd_due) mem_rdata = rd_word;
            else               mem_rdata = 32'hBAD0_BAD0 ^ cyc;
            if (mem_rd) begin
                rd_due  = cyc + LAT;
                rd_word = mem_arr[mem_addr[9:2]];
            end
        end

        always @(negedge clk) begin
            mis_l = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_l = misalign;
`endif
            if (reset) begin
                check_eq($sformatf("L%0d reset outputs", LAT),
                         {req_ready, mem_rd, mem_wr, done, busy, mis_l, |mem_addr, |mem_wdata}, 0);
            end else begin
                if (mem_rd && mem_wr) check_eq($sformatf("L%0d rd/wr overlap", LAT), mem_wr, 0);
                if (mem_rd) begin
                    if (rq.size() == 0) check_eq($sformatf("L%0d unexpected rd", LAT), mem_rd, 0);
                    else begin
                        re = rq.pop_front();
                        check_eq($sformatf("L%0d rd cycle", LAT), cyc, re.cyc);
                        check_eq($sformatf("L%0d rd addr", LAT), mem_addr, re.addr);
                    end
                end
                if (mem_wr || done) begin
                    if (wq.size() == 0) check_eq($sformatf("L%0d unexpected wr/done", LAT), {mem_wr, done}, 0);
                    else begin
                        we = wq.pop_front();
                        check_eq($sformatf("L%0d wr cycle", LAT), cyc, we.cyc);
                        check_eq($sformatf("L%0d wr strobe", LAT), mem_wr, !we.trap);
                        check_eq($sformatf("L%0d done", LAT), done, 1);
                        check_eq($sformatf("L%0d misalign", LAT), mis_l, we.trap);
                        if (!we.trap) begin
                            check_eq($sformatf("L%0d wr addr", LAT), mem_addr, we.addr);
                            check_eq($sformatf("L%0d wr data", LAT), mem_wdata, we.wdata);
                        end
                    end
                end else if (mis_l) begin
                    check_eq($sformatf("L%0d stray misalign", LAT), mis_l, 0);
                end
            end
        end

        // Called at posedge+1; returns at posedge+1 just after the accepting edge.
        task automatic do_req(input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, output int t_acc);
            int          n = 0;
            int          o;
            bit          trap = 1'b0;
            logic [1:0]  es;
            logic [31:0] w;
            wr_exp_t     e;
            rd_exp_t     r;
            req_valid = 1'b1;
            req_size  = sz;
            req_addr  = a;
            req_data  = d;
            @(negedge clk);
            while (!req_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready) begin
                check_eq($sformatf("L%0d accept timeout", LAT), req_ready, 1);
                req_valid = 1'b0;
                t_acc = -1;
                return;
            end
            t_acc = cyc;
            check_eq($sformatf("L%0d idle mem_addr", LAT), mem_addr, 0);
            es = (sz == 2'd3) ? 2'd0 : sz;
`ifdef STORE_MISALIGN_TRAP_EN
            trap = (es == 2'd1 && a[0]) || (es == 2'd0 && a[1:0] != 2'd0);
`endif
            e.addr  = {a[31:2], 2'b00};
            e.trap  = trap;
            e.wdata = '0;
            if (trap) begin
                e.cyc = t_acc + 1;
            end else if (es == 2'd0) begin
                e.cyc   = t_acc + 1;
                e.wdata = d;
                ref_arr[a[9:2]] = d;
            end else begin
                r.cyc  = t_acc + 1;
                r.addr = e.addr;
                rq.push_back(r);
                w = ref_arr[a[9:2]];
                if (es == 2'd2) begin
                    o = int'(a[1:0]);
                    w[o*8 +: 8] = d[7:0];
                end else begin
                    o = a[1] ? 2 : 0;
                    w[o*8 +: 8]     = d[7:0];
                    w[o*8 + 8 +: 8] = d[15:8];
                end
                ref_arr[a[9:2]] = w;
                e.cyc   = t_acc + 2 + LAT;
                e.wdata = w;
            end
            wq.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n = 0;
            @(negedge clk);
            while ((busy || wq.size() != 0) && n < 60) begin
                @(negedge clk);
                n++;
            end
            check_eq($sformatf("L%0d drain", LAT), wq.size(), 0);
            @(posedge clk);
            #1;
        endtask

        initial begin
            int t1, t2, k;
            logic [31:0] saved;
            reset = 1'b1; req_valid = 1'b0; req_size = '0; req_addr = '0; req_data = '0;
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check_eq($sformatf("L%0d ready after reset", LAT), req_ready, 1);
            @(posedge clk);
            #1;

            do_req(2'd0, 32'h100, 32'hDEAD_BEEF, t1);
            wait_idle();
            do_req(2'd2, 32'h143, 32'h0000_00AB, t1);
            wait_idle();
            do_req(2'd1, 32'h182, 32'h0000_CAFE, t1);
            wait_idle();
            check_eq($sformatf("L%0d sw word", LAT), mem_arr[8'h40], 32'hDEAD_BEEF);
            check_eq($sformatf("L%0d sb word", LAT), mem_arr[8'h50], 32'hAB22_3344);
            check_eq($sformatf("L%0d sh word", LAT), mem_arr[8'h60], 32'hCAFE_3344);

            // Reset while the sb sits in WAIT: no write, no done.
            saved = ref_arr[8'h70];
            do_req(2'd2, 32'h1C1, 32'h0000_0099, t1);
            @(posedge clk);
            #1 reset = 1'b1;
            wq.delete();
            ref_arr[8'h70] = saved;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check_eq($sformatf("L%0d ready after mid reset", LAT), {req_ready, busy}, 2'b10);
            repeat (5) @(negedge clk);
            check_eq($sformatf("L%0d aborted word", LAT), mem_arr[8'h70], 32'h1122_3344);
            @(posedge clk);
            #1;

            do_req(2'd2, 32'h201, 32'h0000_005A, t1);
            do_req(2'd2, 32'h202, 32'h0000_0077, t2);
            check_eq($sformatf("L%0d b2b accept", LAT), t2, t1 + 3 + LAT);
            wait_idle();
            check_eq($sformatf("L%0d b2b word", LAT), mem_arr[8'h80], 32'h1177_5A44);

            do_req(2'd1, 32'h241, 32'h0000_BEEF, t1);
            wait_idle();
`ifdef STORE_MISALIGN_TRAP_EN
            check_eq($sformatf("L%0d trapped sh word", LAT), mem_arr[8'h90], 32'h1122_3344);
`else
            check_eq($sformatf("L%0d aligned sh word", LAT), mem_arr[8'h90], 32'h1122_BEEF);
`endif
            do_req(2'd3, 32'h2C0, 32'h0BAD_F00D, t1);
            wait_idle();
            check_eq($sformatf("L%0d reserved size word", LAT), mem_arr[8'hB0], 32'h0BAD_F00D);

            for (int i = 0; i < 24; i++) begin
                do_req(2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom, t1);
                k = $urandom_range(0, 2);
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                end
            end
            wait_idle();
            check_eq($sformatf("L%0d rd queue empty", LAT), rq.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(g_lane[0].fin && g_lane[1].fin) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) check_eq("global timeout", {g_lane[0].fin, g_lane[1].fin}, 2'b11);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Parametrised successor to the combinational store-size merger. Accepts a store request (size, byte address, register data), performs a read-modify-write on the data memory for sub-word stores (sh, sb) and a direct write for sw. Sits between the CPU control unit and the data-memory port and owns that port for the whole store. Adds arbitrary byte-lane placement from the address low bits, configurable memory read latency and a valid/ready request handshake.

## Interface
Parameters:
- DATA_W, 32, memory word width; multiple of 16; LANES = DATA_W/8, OFS_W = log2(LANES)
- ADDR_W, 32, byte-address width
- MEM_LAT, 1, memory read latency in cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_size  in  2  0 = sw, 1 = sh, 2 = sb, 3 = reserved (handled as sw)
- req_addr  in  ADDR_W  byte address
- req_data  in  DATA_W  register data; store payload in its low bits
- mem_addr  out  ADDR_W  word address (req_addr with low OFS_W bits cleared)
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after mem_rd cycle
- mem_wr  out  1  one-cycle write strobe
- mem_wdata  out  DATA_W  write data
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever state ≠ IDLE
- misalign  out  1  present only with STORE_MISALIGN_TRAP_EN

## Operation
- States: IDLE, READ, WAIT, WRITE, TRAP.
- IDLE: req_ready=1. On accept, register size, addr, data. sw/reserved → WRITE; sh/sb → READ.
- READ: mem_rd=1 for one cycle, mem_addr driven → WAIT.
- WAIT: counts MEM_LAT cycles; in the cycle mem_rdata is valid, capture it into merge register → WRITE.
- WRITE: mem_wr=1, done=1, mem_wdata = merged word → IDLE.
- Merge, little-endian, lane offset o = addr[OFS_W-1:0]: sb replaces byte lane o with req_data[7:0]; sh replaces lanes o, o+1 with req_data[15:0]; all other lanes keep captured memory data. sw writes req_data unchanged.
- Alignment without macro: sh uses o with bit 0 cleared, sw ignores o entirely. No access ever spans two words.
- mem_addr holds the registered aligned address from READ through WRITE; 0 in IDLE.
- req_valid while busy is ignored (req_ready=0); no queuing.

## Timing
- Reset: every output 0 while reset high, including req_ready; state IDLE. req_ready=1 in the first cycle after reset falls.
- Reset mid-operation: next edge → IDLE, no mem_wr or done issued; a pending read result is discarded.
- Accept at cycle t. sw: WRITE (mem_wr, done) at t+1. sh/sb: mem_rd at t+1, capture at t+1+MEM_LAT, mem_wr+done at t+2+MEM_LAT.
- Back-to-back: next request can be accepted in the cycle after done (req_ready rises with return to IDLE).
- mem_rd and mem_wr never high in the same cycle.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: sh with addr[0]=1, or sw with addr[OFS_W-1:0]≠0, goes IDLE → TRAP; TRAP asserts done=1 and misalign=1 for one cycle, no mem_rd or mem_wr, → IDLE. misalign is 0 in all other cycles and under reset.
- Undefined: misalign port and TRAP state absent; low bits silently aligned as in Operation.

## Structure
- Package store_pkg: size encodings SZ_WORD=2'd0, SZ_HALF=2'd1, SZ_BYTE=2'd2; state encodings; lane-mask function (size, offset) → LANES-bit byte mask.
- Sub-module store_lane_merge: combinational, inputs size, offset, reg data, mem data; output merged word. FSM and counter live in store_rmw_unit.

## Test plan
- sw, addr 0x100, data 0xDEADBEEF → cycle t+1: mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_rd never asserted.
- sb, addr 0x103, data 0x000000AB, memory word 0x11223344, MEM_LAT=1 → mem_rd at t+1, mem_wr at t+3 with mem_wdata=0xAB223344.
- sh, addr 0x102, data 0x0000CAFE, memory 0x11223344, MEM_LAT=3 → mem_wr at t+5, mem_wdata=0xCAFE3344, mem_addr=0x100.
- Reset asserted in WAIT of an sb → no mem_wr, no done; outputs 0; req_ready=1 the cycle after reset falls.
- Two back-to-back sb requests, second held valid during busy → second accepted in the cycle after first done, both writes correct.
- With macro, sh at 0x101 → done=1, misalign=1 at t+1, no memory strobe; without macro same request writes lanes 0–1 at 0x100.
